// File: rtl/uart_irq_sched.sv
// Interrupt scheduler sharing one interrupt line among NCH UART channels.
// Level requests are masked, then handed out one at a time through a
// claim/acknowledge handshake with round-robin fairness. A holdoff timer,
// loaded on each completed service, delays the next interrupt.
//
// Handshake: claim_rd is a one-cycle strobe; exactly one cycle later
// rsp_valid pulses for one cycle, with claim_ok/claim_id describing the
// result. claim_ok and claim_id hold until the next response. Only one claim
// is outstanding at a time; it ends with an ack_wr whose ack_id matches
// claim_id. Mismatched acks, and acks outside CLAIMED, are ignored.
module uart_irq_sched #(
    parameter int NCH   = 8,
    parameter int IDW   = $clog2(NCH),
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic             mask_wr,
    input  logic [NCH-1:0]   mask_wdata,
    input  logic             coal_wr,
    input  logic [CNT_W-1:0] coal_wdata,
    input  logic             claim_rd,
    input  logic             ack_wr,
    input  logic [IDW-1:0]   ack_id,
    output logic             irq,
    output logic             rsp_valid,
    output logic             claim_ok,
    output logic [IDW-1:0]   claim_id,
    output logic [NCH-1:0]   in_service,
    output logic [NCH-1:0]   pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        CLAIMED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   mask_q;
    logic [CNT_W-1:0] coal_q;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             irq_q, irq_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             claim_ok_q, claim_ok_d;
    logic [IDW-1:0]   claim_id_q, claim_id_d;
    logic [NCH-1:0]   in_service_q, in_service_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_idx;

    // Channels eligible for service right now.
    assign pending    = req & ~mask_q & ~in_service_q;

    assign irq        = irq_q;
    assign rsp_valid  = rsp_valid_q;
    assign claim_ok   = claim_ok_q;
    assign claim_id   = claim_id_q;
    assign in_service = in_service_q;

    // Host configuration registers; a write becomes visible the next cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            mask_q <= '1;
            coal_q <= '0;
        end else begin
            if (mask_wr) mask_q <= mask_wdata;
            if (coal_wr) coal_q <= coal_wdata;
        end
    end

    // Round-robin search: first pending channel at or above ptr, wrapping.
    // NCH is a power of two, so the IDW-bit add wraps modulo NCH for free.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            scan_idx = ptr_q + IDW'(i);
            if (!grant_found && pending[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // Next-state and registered-output logic for the claim state machine.
    always_comb begin
        state_d      = state_q;
        irq_d        = 1'b0;
        rsp_valid_d  = 1'b0;
        claim_ok_d   = claim_ok_q;
        claim_id_d   = claim_id_q;
        in_service_d = in_service_q;
        ptr_d        = ptr_q;
        hold_d       = (hold_q != '0) ? hold_q - 1'b1 : hold_q;

        case (state_q)
            IDLE: begin
                if (claim_rd) begin
                    rsp_valid_d = 1'b1;
                    claim_ok_d  = 1'b0;
                end
                if ((|pending) && (hold_q == '0)) begin
                    state_d = ASSERT;
                    irq_d   = 1'b1;
                end
            end
            ASSERT: begin
                if (claim_rd) begin
                    rsp_valid_d = 1'b1;
                    if (grant_found) begin
                        claim_ok_d             = 1'b1;
                        claim_id_d             = grant_id;
                        in_service_d           = '0;
                        in_service_d[grant_id] = 1'b1;
                        ptr_d                  = grant_id + 1'b1;
                        state_d                = CLAIMED;
                    end else begin
                        claim_ok_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (!(|pending)) begin
                    state_d = IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            CLAIMED: begin
                // A claim here is refused even when it arrives with the ack.
                if (claim_rd) begin
                    rsp_valid_d = 1'b1;
                    claim_ok_d  = 1'b0;
                end
                if (ack_wr && (ack_id == claim_id_q)) begin
                    in_service_d = '0;
                    hold_d       = coal_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any outstanding claim.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            ptr_q        <= '0;
            irq_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            claim_ok_q   <= 1'b0;
            claim_id_q   <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            ptr_q        <= ptr_d;
            irq_q        <= irq_d;
            rsp_valid_q  <= rsp_valid_d;
            claim_ok_q   <= claim_ok_d;
            claim_id_q   <= claim_id_d;
            in_service_q <= in_service_d;
        end
    end

endmodule

// File: tb/tb_uart_irq_sched.sv
// Directed bench for uart_irq_sched: claim responses go through an
// expected queue checked by a monitor; timing points are checked inline.
module tb_uart_irq_sched;

    localparam int NCH   = 8;
    localparam int IDW   = 3;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   req = '0;
    logic             mask_wr = 1'b0;
    logic [NCH-1:0]   mask_wdata = '0;
    logic             coal_wr = 1'b0;
    logic [CNT_W-1:0] coal_wdata = '0;
    logic             claim_rd = 1'b0;
    logic             ack_wr = 1'b0;
    logic [IDW-1:0]   ack_id = '0;
    logic             irq;
    logic             rsp_valid;
    logic             claim_ok;
    logic [IDW-1:0]   claim_id;
    logic [NCH-1:0]   in_service;
    logic [NCH-1:0]   pending;

    // Expected responses: {claim_ok, claim_id}
    logic [IDW:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    uart_irq_sched #(.NCH(NCH), .IDW(IDW), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req        (req),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .coal_wr    (coal_wr),
        .coal_wdata (coal_wdata),
        .claim_rd   (claim_rd),
        .ack_wr     (ack_wr),
        .ack_id     (ack_id),
        .irq        (irq),
        .rsp_valid  (rsp_valid),
        .claim_ok   (claim_ok),
        .claim_id   (claim_id),
        .in_service (in_service),
        .pending    (pending)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mask_wr = 1'b0; coal_wr = 1'b0; claim_rd = 1'b0; ack_wr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input logic [NCH-1:0] m, input logic [CNT_W-1:0] c);
        mask_wr = 1'b1; mask_wdata = m;
        coal_wr = 1'b1; coal_wdata = c;
        tick();
        mask_wr = 1'b0; coal_wr = 1'b0;
    endtask

    task automatic claim(input logic ok, input logic [IDW-1:0] id);
        exp_q.push_back({ok, id});
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
    endtask

    task automatic ack(input logic [IDW-1:0] id);
        ack_wr = 1'b1; ack_id = id;
        tick();
        ack_wr = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int n;
        n = 0;
        while (!irq && n < budget) begin
            tick();
            n++;
        end
        chk("irq_wait", {31'd0, irq}, 32'd1);
    endtask

    // Monitor: every response must match the head of the expected queue.
    always @(negedge CLK) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=ok%0d_id%0d expected=none", claim_ok, claim_id);
            end else begin
                logic [IDW:0] e;
                e = exp_q.pop_front();
                checks++;
                if (claim_ok !== e[IDW] || (e[IDW] && claim_id !== e[IDW-1:0])) begin
                    failures++;
                    $display("FAIL rsp actual=ok%0d_id%0d expected=ok%0d_id%0d",
                             claim_ok, claim_id, e[IDW], e[IDW-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state; mask is all ones so requests are not pending.
        req = 8'h24;
        do_reset();
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_claim_ok", {31'd0, claim_ok}, 0);
        chk("rst_claim_id", {29'd0, claim_id}, 0);
        chk("rst_in_service", {24'd0, in_service}, 0);
        chk("rst_pending", {24'd0, pending}, 0);

        // Basic flow: unmask together with req, irq 2 cycles later.
        write_cfg(8'h00, 16'd0);
        chk("basic_irq_early", {31'd0, irq}, 0);
        chk("basic_pending", {24'd0, pending}, 32'h24);
        tick();
        chk("basic_irq_rise", {31'd0, irq}, 1);
        claim(1'b1, 3'd2);
        chk("basic_irq_fall", {31'd0, irq}, 0);
        chk("basic_in_service", {24'd0, in_service}, 32'h04);
        chk("basic_pending_excl", {24'd0, pending}, 32'h20);
        ack(3'd2);
        chk("basic_in_service_clr", {24'd0, in_service}, 0);
        tick();
        chk("basic_irq_h0", {31'd0, irq}, 1);
        claim(1'b1, 3'd5);
        ack(3'd5);

        // Fairness: all channels requesting.
        req = 8'h00;
        do_reset();
        req = 8'hFF;
        write_cfg(8'h00, 16'd0);
        for (int k = 0; k < 16; k++) begin
            wait_irq(4);
            claim(1'b1, 3'(k % 8));
            ack(3'(k % 8));
        end

        // Holdoff of 10; a coal write during countdown affects only the next load.
        req = 8'h00;
        do_reset();
        req = 8'h01;
        write_cfg(8'h00, 16'd10);
        wait_irq(4);
        claim(1'b1, 3'd0);
        ack(3'd0);
        for (int i = 1; i <= 11; i++) begin
            chk("hold10_quiet", {31'd0, irq}, 0);
            if (i == 3) begin
                coal_wr = 1'b1; coal_wdata = 16'd3;
            end
            tick();
            coal_wr = 1'b0;
        end
        chk("hold10_rise", {31'd0, irq}, 1);
        claim(1'b1, 3'd0);
        ack(3'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("hold3_quiet", {31'd0, irq}, 0);
            tick();
        end
        chk("hold3_rise", {31'd0, irq}, 1);

        // Mask: channel 1 masked, then unmasked.
        req = 8'h00;
        do_reset();
        req = 8'h02;
        write_cfg(8'hFE, 16'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mask_quiet", {31'd0, irq}, 0);
            tick();
        end
        claim(1'b0, 3'd0);
        mask_wr = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_wr = 1'b0;
        chk("unmask_early", {31'd0, irq}, 0);
        tick();
        chk("unmask_rise", {31'd0, irq}, 1);
        claim(1'b1, 3'd1);
        ack(3'd1);

        // Handshake errors while channel 3 is claimed.
        req = 8'h00;
        do_reset();
        req = 8'h08;
        write_cfg(8'h00, 16'd0);
        wait_irq(4);
        claim(1'b1, 3'd3);
        ack(3'd4);
        chk("bad_ack_in_service", {24'd0, in_service}, 32'h08);
        chk("bad_ack_irq", {31'd0, irq}, 0);
        chk("bad_ack_pending", {24'd0, pending}, 0);
        claim(1'b0, 3'd0);
        chk("second_claim_in_service", {24'd0, in_service}, 32'h08);
        exp_q.push_back({1'b0, 3'd0});
        claim_rd = 1'b1; ack_wr = 1'b1; ack_id = 3'd3;
        tick();
        claim_rd = 1'b0; ack_wr = 1'b0;
        chk("good_ack_in_service", {24'd0, in_service}, 0);

        // Request withdrawal while asserted.
        req = 8'h00;
        do_reset();
        req = 8'h10;
        write_cfg(8'h00, 16'd0);
        wait_irq(4);
        req = 8'h00;
        tick();
        if (irq) tick();
        chk("withdraw_irq", {31'd0, irq}, 0);

        // Reset while claimed, with a claim in flight: no response.
        req = 8'h10;
        wait_irq(4);
        claim(1'b1, 3'd4);
        chk("pre_reset_in_service", {24'd0, in_service}, 32'h10);
        reset = 1'b1; claim_rd = 1'b1;
        tick();
        reset = 1'b0; claim_rd = 1'b0;
        chk("mid_rst_irq", {31'd0, irq}, 0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_claim_ok", {31'd0, claim_ok}, 0);
        chk("mid_rst_claim_id", {29'd0, claim_id}, 0);
        chk("mid_rst_in_service", {24'd0, in_service}, 0);
        chk("mid_rst_pending", {24'd0, pending}, 0);

        tick();
        tick();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_irq_sched.md
# uart_irq_sched

Interrupt scheduler that shares the single PL-to-PS interrupt line among the eight UART channels behind the AXI slave. It collects per-channel level service requests, applies a host-written mask, and hands out one channel at a time through a claim/acknowledge handshake. A programmable holdoff timer coalesces interrupts between services. It sits between the UART channel array and the `irq` output of the top-level design.

## Interface
- `NCH`, 8: number of channels; power of two, 2..16.
- `IDW`, $clog2(NCH): channel id width.
- `CNT_W`, 16: holdoff counter width.

- `CLK`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NCH  level service request per channel, from UART RX-nonempty or TX-low.
- `mask_wr`  in  1  one-cycle strobe that loads `mask_wdata` into the mask register.
- `mask_wdata`  in  NCH  mask value; bit=1 masks that channel.
- `coal_wr`  in  1  one-cycle strobe that loads `coal_wdata` into the holdoff register.
- `coal_wdata`  in  CNT_W  holdoff length in cycles; 0 disables holdoff.
- `claim_rd`  in  1  one-cycle claim request from the host read path.
- `ack_wr`  in  1  one-cycle completion strobe.
- `ack_id`  in  IDW  id being completed.
- `irq`  out  1  interrupt to the PS.
- `rsp_valid`  out  1  one-cycle claim response strobe.
- `claim_ok`  out  1  response carries a granted channel.
- `claim_id`  out  IDW  granted channel id.
- `in_service`  out  NCH  channel currently claimed; one-hot or zero.
- `pending`  out  NCH  `req & ~mask & ~in_service`, combinational.

## Operation
- State machine states: IDLE, ASSERT, CLAIMED. `ptr` is the round-robin start pointer, IDW bits wide.
- IDLE:
  - Go to ASSERT when `|pending` and `hold_cnt==0`.
  - `claim_rd` returns a response with `claim_ok=0`.
- ASSERT:
  - `irq=1`.
  - On `claim_rd` with `|pending`: grant the first set `pending` bit searching upward from `ptr`, with modulo-NCH wrap. Set `in_service[g]`. Set `ptr` to `(g+1) mod NCH`. Respond with `claim_ok=1` and `claim_id=g`. Go to CLAIMED.
  - On `claim_rd` with `pending==0`: respond with `claim_ok=0` and go to IDLE.
  - If `pending` becomes 0 without a claim, go to IDLE.
- CLAIMED:
  - `irq=0`.
  - On `ack_wr` with `ack_id==claim_id`: clear `in_service`, load `hold_cnt` with the holdoff register value, go to IDLE.
  - A mismatched `ack_wr` is ignored.
  - `claim_rd` returns `claim_ok=0`; only one claim is outstanding at a time.
- `ack_wr` in IDLE or ASSERT is ignored.
- `hold_cnt` decrements by 1 each cycle while nonzero and saturates at 0.
- A `coal_wr` during a countdown changes only future loads; the running count is unaffected.
- `mask_wr` takes effect the cycle after the strobe. A `claim_rd` in the same cycle uses the old mask.
- Reset mid-operation drops any claim: `in_service` is cleared and no response is produced for a pending `claim_rd`.

## Timing
- Reset values:
  - `irq=0`, `rsp_valid=0`, `claim_ok=0`, `claim_id=0`, `in_service=0`.
  - `mask` all ones, so all channels are masked out of reset.
  - Holdoff register 0, `hold_cnt=0`, `ptr=0`, state IDLE.
- `irq` is registered. It rises 1 cycle after the cycle in which IDLE sees `|pending && hold_cnt==0`.
- Claim response: `rsp_valid` pulses for exactly 1 cycle, the cycle after `claim_rd`. `claim_ok` and `claim_id` hold their values until the next response.
- `irq` falls in the same cycle `rsp_valid` rises.
- After a matching ack, IDLE is entered the next cycle. With holdoff H>0, the earliest next `irq` rise is H+1 cycles after the cycle following the ack. With H=0 it is 1 cycle after IDLE is entered.
- `claim_rd` and `ack_wr` asserted in the same cycle while in CLAIMED: the ack is processed and the claim returns `claim_ok=0`.

## Test plan
- Reset, write `mask=0x00`, `coal=0`, drive `req=0x24` → `irq` rises 2 cycles after `req`. First claim returns id 2 with `ptr=3`. After ack of id 2, the next claim returns id 5.
- Fairness: hold `req=0xFF` and run claim/ack 16 times → ids come out 0..7, 0..7 in order.
- Holdoff: `coal=10`, `req=0x01`, claim then ack at cycle T → `irq` stays 0 through T+11 and rises at T+12.
- Mask: `mask=0xFE` with `req=0x02` → `irq` stays 0 and `claim_rd` returns `claim_ok=0`. Write `mask=0x00` → `irq` rises 2 cycles later.
- Handshake errors: in CLAIMED with id 3, ack id 4 → state and `in_service=0x08` unchanged. A second `claim_rd` returns `claim_ok=0`. Ack id 3 → `in_service=0`.
- Request withdrawal and reset: `req` drops to 0 in ASSERT → `irq` falls within 2 cycles. Asserting `reset` in CLAIMED → all outputs return to reset values on the next cycle.
